// File: rtl/wt_dcache_inval_seq.sv
// wt_dcache_inval_seq: full-flush and single-line invalidation sequencer for dcache write port 0
module wt_dcache_inval_seq #(
  parameter int unsigned NumIdx       = 256,
  parameter int unsigned NumWays      = 8,
  parameter bit          FlushOnReset = 1'b1,
  parameter int unsigned TagWidth     = 44,
  localparam int unsigned IdxWidth    = $clog2(NumIdx)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  output logic                flush_ack_o,
  input  logic                inval_vld_i,
  input  logic [IdxWidth-1:0] inval_idx_i,
  input  logic [NumWays-1:0]  inval_way_oh_i,
  output logic                inval_ack_o,
  output logic                busy_o,
  output logic                wr_cl_vld_o,
  output logic [NumWays-1:0]  wr_cl_we_o,
  output logic [IdxWidth-1:0] wr_cl_idx_o,
  output logic [TagWidth-1:0] wr_cl_tag_o,
  output logic [NumWays-1:0]  wr_vld_bits_o,
  input  logic                wr_cl_gnt_i
);
  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, INVAL = 2'd2} state_e;
  state_e state_q, state_d;
  logic [IdxWidth-1:0] cnt_q, cnt_d, inv_idx_q, inv_idx_d;
  logic [NumWays-1:0] inv_way_q, inv_way_d;
  logic flush_pend_q, flush_pend_d;
  logic last, done, go, want_flush, cap;
  always_comb begin
    last         = cnt_q == IdxWidth'(NumIdx - 1);
    done         = state_q == FLUSH && wr_cl_gnt_i && last;
    go           = state_q == IDLE || done;
    want_flush   = flush_pend_q | flush_i;
    cap          = go && !want_flush && inval_vld_i;
    state_d      = go ? (want_flush ? FLUSH : inval_vld_i ? INVAL : IDLE)
                 : (state_q == INVAL && wr_cl_gnt_i) ? IDLE : state_q;
    cnt_d        = (go && want_flush) ? '0
                 : (state_q == FLUSH && wr_cl_gnt_i) ? cnt_q + IdxWidth'(1) : cnt_q;
    flush_pend_d = (go && want_flush) ? flush_pend_q & flush_i : want_flush;
    inv_idx_d    = cap ? inval_idx_i : inv_idx_q;
    inv_way_d    = cap ? inval_way_oh_i : inv_way_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      inv_idx_q    <= '0;
      inv_way_q    <= '0;
      flush_pend_q <= FlushOnReset;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      inv_idx_q    <= inv_idx_d;
      inv_way_q    <= inv_way_d;
      flush_pend_q <= flush_pend_d;
    end
  end
  assign wr_cl_vld_o   = state_q != IDLE;
  assign wr_cl_we_o    = state_q == FLUSH ? {NumWays{1'b1}} : state_q == INVAL ? inv_way_q : '0;
  assign wr_cl_idx_o   = state_q == FLUSH ? cnt_q : state_q == INVAL ? inv_idx_q : '0;
  assign wr_cl_tag_o   = '0;
  assign wr_vld_bits_o = '0;
  assign flush_ack_o   = !rst_i && done;
  assign inval_ack_o   = !rst_i && state_q == INVAL && wr_cl_gnt_i;
  assign busy_o        = state_q != IDLE || flush_pend_q;
endmodule

// File: tb/tb_wt_dcache_inval_seq.sv
// tb_wt_dcache_inval_seq: directed vector and sequence checks of the invalidation sequencer
module tb_wt_dcache_inval_seq;
  logic clk = 1'b0;
  logic rst = 1'b1, flush_i = 1'b0, inval_vld_i = 1'b0, gnt = 1'b1;
  logic [2:0] inval_idx_i = '0;
  logic [7:0] inval_way_oh_i = '0;
  logic flush_ack_o, inval_ack_o, busy_o, wr_cl_vld_o;
  logic [7:0] wr_cl_we_o, wr_vld_bits_o;
  logic [2:0] wr_cl_idx_o;
  logic [19:0] wr_cl_tag_o;
  logic rst0 = 1'b1, flush0 = 1'b0, gnt0 = 1'b1;
  logic fack0, iack0, busy0, vld0;
  logic [7:0] we0, vb0;
  logic [2:0] idx0;
  logic [19:0] tag0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  wt_dcache_inval_seq #(.NumIdx(8), .NumWays(8), .FlushOnReset(1'b1), .TagWidth(20)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_i), .flush_ack_o(flush_ack_o),
    .inval_vld_i(inval_vld_i), .inval_idx_i(inval_idx_i), .inval_way_oh_i(inval_way_oh_i),
    .inval_ack_o(inval_ack_o), .busy_o(busy_o), .wr_cl_vld_o(wr_cl_vld_o), .wr_cl_we_o(wr_cl_we_o),
    .wr_cl_idx_o(wr_cl_idx_o), .wr_cl_tag_o(wr_cl_tag_o), .wr_vld_bits_o(wr_vld_bits_o),
    .wr_cl_gnt_i(gnt)
  );
  wt_dcache_inval_seq #(.NumIdx(8), .NumWays(8), .FlushOnReset(1'b0), .TagWidth(20)) dut0 (
    .clk_i(clk), .rst_i(rst0), .flush_i(flush0), .flush_ack_o(fack0),
    .inval_vld_i(1'b0), .inval_idx_i(3'd0), .inval_way_oh_i(8'h00),
    .inval_ack_o(iack0), .busy_o(busy0), .wr_cl_vld_o(vld0), .wr_cl_we_o(we0),
    .wr_cl_idx_o(idx0), .wr_cl_tag_o(tag0), .wr_vld_bits_o(vb0), .wr_cl_gnt_i(gnt0)
  );
  typedef struct {
    logic rst, fl, iv;
    logic [2:0] ii;
    logic [7:0] iw;
    logic g, e_vld;
    logic [7:0] e_we;
    logic [2:0] e_idx;
    logic e_fa, e_ia, e_busy;
  } vec_t;
  vec_t tbl[$];
  function automatic void add(logic r, logic f, logic v, logic [2:0] ii, logic [7:0] iw, logic g,
                              logic ev, logic [7:0] ew, logic [2:0] ei, logic fa, logic ia, logic eb);
    tbl.push_back('{r, f, v, ii, iw, g, ev, ew, ei, fa, ia, eb});
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_seq(input bit two, output int f1, output int f2, output int ia,
                         output logic [2:0] idx_after, output logic vld_after);
    bit held = 0;
    f1 = -1; f2 = -1; ia = -1; idx_after = '0; vld_after = 1'b0;
    gnt = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      flush_i = (c == 0) || (two && (c == 2 || c == 4));
      if (c == (two ? 2 : 0)) held = 1;
      inval_vld_i = held;
      inval_idx_i = 3'd6;
      inval_way_oh_i = 8'h81;
      #1;
      if (f1 >= 0 && c == f1 + 1) begin
        idx_after = wr_cl_idx_o;
        vld_after = wr_cl_vld_o;
      end
      chk($sformatf("acks_exclusive c%0d", c), {31'd0, flush_ack_o & inval_ack_o}, 0);
      if (flush_ack_o) begin
        if (f1 < 0) f1 = c;
        else f2 = c;
      end
      if (inval_ack_o) begin
        ia = c;
        chk("seq_inval_idx", {29'd0, wr_cl_idx_o}, 6);
        chk("seq_inval_we", {24'd0, wr_cl_we_o}, 32'h81);
        held = 0;
      end
    end
    flush_i = 1'b0;
    inval_vld_i = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int f1, f2, ia, nw, drops, writes;
    logic [2:0] ia_idx;
    logic ia_vld;
    bit found, fin;
    add(1, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 1);
    add(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++) add(0, 0, 0, 0, 8'h00, 1, 1, 8'hFF, 3'(k), k == 7, 0, 1);
    add(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 0, 1, 5, 8'h04, 0, 0, 8'h00, 0, 0, 0, 0);
    add(0, 0, 1, 5, 8'h04, 0, 1, 8'h04, 5, 0, 0, 1);
    add(0, 0, 1, 2, 8'h10, 0, 1, 8'h04, 5, 0, 0, 1);
    add(0, 0, 1, 5, 8'h04, 0, 1, 8'h04, 5, 0, 0, 1);
    add(0, 0, 1, 5, 8'h04, 1, 1, 8'h04, 5, 0, 1, 1);
    add(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
    writes = 0;
    foreach (tbl[i]) begin
      tick();
      rst = tbl[i].rst; flush_i = tbl[i].fl; inval_vld_i = tbl[i].iv;
      inval_idx_i = tbl[i].ii; inval_way_oh_i = tbl[i].iw; gnt = tbl[i].g;
      #1;
      chk($sformatf("row%0d vld", i), {31'd0, wr_cl_vld_o}, {31'd0, tbl[i].e_vld});
      chk($sformatf("row%0d we", i), {24'd0, wr_cl_we_o}, {24'd0, tbl[i].e_we});
      chk($sformatf("row%0d idx", i), {29'd0, wr_cl_idx_o}, {29'd0, tbl[i].e_idx});
      chk($sformatf("row%0d flush_ack", i), {31'd0, flush_ack_o}, {31'd0, tbl[i].e_fa});
      chk($sformatf("row%0d inval_ack", i), {31'd0, inval_ack_o}, {31'd0, tbl[i].e_ia});
      chk($sformatf("row%0d busy", i), {31'd0, busy_o}, {31'd0, tbl[i].e_busy});
      chk($sformatf("row%0d zeros", i), {4'd0, wr_cl_tag_o, wr_vld_bits_o}, 0);
      if (wr_cl_vld_o && gnt) writes++;
    end
    chk("table_write_count", writes, 9);
    run_seq(1'b1, f1, f2, ia, ia_idx, ia_vld);
    chk("t4_first_ack_cycle", f1, 8);
    chk("t4_second_sweep_vld", {31'd0, ia_vld}, 1);
    chk("t4_second_sweep_idx0", {29'd0, ia_idx}, 0);
    chk("t4_second_ack_cycle", f2, 16);
    chk("t4_inval_ack_cycle", ia, 17);
    run_seq(1'b0, f1, f2, ia, ia_idx, ia_vld);
    chk("t6_flush_ack_cycle", f1, 8);
    chk("t6_no_second_flush", f2, -1);
    chk("t6_inval_ack_cycle", ia, 9);
    nw = 0; drops = 0; fin = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      flush_i = (c == 0);
      if (wr_cl_vld_o && wr_cl_idx_o == 3'd3 && drops < 2) begin
        gnt = 1'b0;
        drops++;
      end else gnt = 1'b1;
      #1;
      if (!gnt) begin
        chk($sformatf("t3_hold_idx c%0d", c), {29'd0, wr_cl_idx_o}, 3);
        chk($sformatf("t3_hold_vld c%0d", c), {31'd0, wr_cl_vld_o}, 1);
        chk($sformatf("t3_hold_noack c%0d", c), {31'd0, flush_ack_o}, 0);
      end
      if (!fin && wr_cl_vld_o && gnt) begin
        chk($sformatf("t3_write%0d_idx", nw), {29'd0, wr_cl_idx_o}, nw);
        nw++;
        if (flush_ack_o) fin = 1;
      end
    end
    chk("t3_ack_seen", {31'd0, fin}, 1);
    chk("t3_granted_writes", nw, 8);
    chk("t3_drops", drops, 2);
    gnt = 1'b1;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      #1;
      found = wr_cl_vld_o && wr_cl_idx_o == 3'd7;
      if (!found) tick();
    end
    chk("rst_reach_last", {31'd0, found}, 1);
    rst = 1'b1;
    #1;
    chk("rst_gates_flush_ack", {31'd0, flush_ack_o}, 0);
    chk("rst_gates_inval_ack", {31'd0, inval_ack_o}, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_after_vld", {31'd0, wr_cl_vld_o}, 0);
    chk("rst_after_pend_busy", {31'd0, busy_o}, 1);
    tick();
    rst0 = 1'b0;
    #1;
    chk("t5_reset_vld", {31'd0, vld0}, 0);
    chk("t5_reset_busy", {31'd0, busy0}, 0);
    tick();
    flush0 = 1'b1;
    tick();
    flush0 = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      #1;
      found = vld0 && idx0 == 3'd4;
      if (!found) tick();
    end
    chk("t5_reach_cnt4", {31'd0, found}, 1);
    rst0 = 1'b1;
    #1;
    chk("t5_rst_cycle_ack", {31'd0, fack0}, 0);
    tick();
    rst0 = 1'b0;
    #1;
    chk("t5_after_vld", {31'd0, vld0}, 0);
    chk("t5_after_busy", {31'd0, busy0}, 0);
    chk("t5_after_ack", {31'd0, fack0}, 0);
    tick();
    chk("t5_stays_idle", {31'd0, vld0 | busy0}, 0);
    flush0 = 1'b1;
    tick();
    flush0 = 1'b0;
    #1;
    chk("t5_restart_vld", {31'd0, vld0}, 1);
    chk("t5_restart_idx", {29'd0, idx0}, 0);
    chk("t5_restart_we", {24'd0, we0}, 32'hFF);
    chk("t5_no_inval_ack", {31'd0, iack0}, 0);
    chk("t5_zeros", {4'd0, tag0, vb0}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
